mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64, max cycles a granted transaction waits for ext_data_ready before abort (range 2..255).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 imem_addr_valid  input  1  icache requests an external line read.
REQ-005 imem_addr  input  32  icache line address.
REQ-006 imem_data_ready  output  1  one-cycle pulse: line for icache is on ext_read_data.
REQ-007 dmem_addr_valid  input  1  dcache requests an external line read or write.
REQ-008 dmem_addr  input  32  dcache line address.
REQ-009 dmem_write_data_valid  input  1  dcache request is a write.
REQ-010 dmem_write_data  input  512  dcache writeback line.
REQ-011 dmem_data_ready  output  1  one-cycle pulse: dcache transaction complete.
REQ-012 ext_addr_valid  output  1  registered request to rom/ram.
REQ-013 ext_addr  output  32  registered address to rom/ram.
REQ-014 ext_write_data_valid  output  1  registered write strobe to ram.
REQ-015 ext_write_data  output  512  registered write line.
REQ-016 ext_data_ready  input  1  slave completion (read data valid or write accepted).
REQ-017 bus_error  output  1  one-cycle pulse on timeout abort.

Function
REQ-018 States: IDLE, GRANT_I, GRANT_D, TURN; encoding free.
REQ-019 IDLE, no request: outputs ext_addr_valid=0, ext_write_data_valid=0; stay IDLE.
REQ-020 IDLE, only imem_addr_valid: latch imem_addr into ext_addr, ext_addr_valid=1 next cycle, go GRANT_I.
REQ-021 IDLE, only dmem_addr_valid: latch dmem_addr, dmem_write_data, dmem_write_data_valid into ext_* registers, go GRANT_D.
REQ-022 IDLE, both valid: grant the requester NOT served last (round-robin flag last_d); after reset last_d=1, so icache wins first tie.
REQ-023 Request-to-ext_addr_valid latency: exactly 1 cycle.
REQ-024 GRANT_x: ext_addr, ext_write_data, ext_write_data_valid held stable; requester inputs ignored while granted.
REQ-025 GRANT_x with ext_data_ready=1: pulse matching imem_data_ready or dmem_data_ready combinationally in that same cycle; deassert ext_addr_valid and ext_write_data_valid next edge; update last_d; go TURN.
REQ-026 Ready pulses never go to the non-granted cache; ext_data_ready in IDLE or TURN ignored.
REQ-027 TURN: one idle cycle, ext_addr_valid=0, so slaves drop data_ready; then IDLE.
REQ-028 Timeout: 8-bit counter cleared on entering GRANT_x, incremented each GRANT cycle without ext_data_ready; on reaching TIMEOUT pulse bus_error for one cycle, no data_ready pulse, deassert ext strobes, go TURN.
REQ-029 ext_data_ready in the same cycle the counter hits TIMEOUT: completion wins, bus_error stays 0.
REQ-030 A request dropped by a cache mid-grant does not abort; transaction runs to completion or timeout.
REQ-031 Max back-to-back throughput: one transaction per (grant cycles + 2).
REQ-032 Read data is not registered here; ext_read_data routes directly to both caches.

Reset
REQ-033 rst low asynchronously forces IDLE, ext_addr_valid=0, ext_addr=0, ext_write_data_valid=0, ext_write_data=0, imem_data_ready=0, dmem_data_ready=0, bus_error=0, counter=0, last_d=1.
REQ-034 Reset asserted mid-grant abandons the transaction with no ready pulse; first request after rst release is handled as from IDLE.

Verification
REQ-035 imem-only read of 0x00000040, slave ready 3 cycles after ext_addr_valid -> ext_addr=0x40 one cycle after request, one imem_data_ready pulse, no dmem_data_ready.
REQ-036 dmem write 0x00008000, data pattern 0xA5 repeated -> ext_write_data_valid=1 with same data until ready; dmem_data_ready one pulse; TURN cycle seen.
REQ-037 Both request continuously after reset -> grants alternate I, D, I, D across four transactions.
REQ-038 No slave response, TIMEOUT=8 -> bus_error pulses exactly 8 cycles after grant, no data_ready, returns IDLE after TURN.
REQ-039 Ready coincident with 8th wait cycle -> data_ready pulses, bus_error=0.
REQ-040 rst low during GRANT_D -> all outputs 0 immediately; after release, pending imem request granted first.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master arbiter (icache, dcache) onto a single external rom/ram port.
// Round-robin on ties, one TURN cycle after every transaction, timeout abort with bus_error.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         imem_addr_valid,
    input  logic [31:0]  imem_addr,
    output logic         imem_data_ready,
    input  logic         dmem_addr_valid,
    input  logic [31:0]  dmem_addr,
    input  logic         dmem_write_data_valid,
    input  logic [511:0] dmem_write_data,
    output logic         dmem_data_ready,
    output logic         ext_addr_valid,
    output logic [31:0]  ext_addr,
    output logic         ext_write_data_valid,
    output logic [511:0] ext_write_data,
    input  logic         ext_data_ready,
    output logic         bus_error
);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, TURN} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t       state_q, state_d;
    logic         ext_addr_valid_q, ext_addr_valid_d;
    logic [31:0]  ext_addr_q, ext_addr_d;
    logic         ext_wdv_q, ext_wdv_d;
    logic [511:0] ext_wdata_q, ext_wdata_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         last_dmem_q, last_dmem_d;

    always_comb begin
        state_d          = state_q;
        ext_addr_valid_d = ext_addr_valid_q;
        ext_addr_d       = ext_addr_q;
        ext_wdv_d        = ext_wdv_q;
        ext_wdata_d      = ext_wdata_q;
        cnt_d            = cnt_q;
        last_dmem_d      = last_dmem_q;
        imem_data_ready  = 1'b0;
        dmem_data_ready  = 1'b0;
        bus_error        = 1'b0;

        case (state_q)
            IDLE: begin
                // icache wins a tie only when dcache was served last
                if (imem_addr_valid && (!dmem_addr_valid || last_dmem_q)) begin
                    ext_addr_d       = imem_addr;
                    ext_addr_valid_d = 1'b1;
                    ext_wdv_d        = 1'b0;
                    cnt_d            = '0;
                    state_d          = GRANT_I;
                end else if (dmem_addr_valid) begin
                    ext_addr_d       = dmem_addr;
                    ext_wdata_d      = dmem_write_data;
                    ext_wdv_d        = dmem_write_data_valid;
                    ext_addr_valid_d = 1'b1;
                    cnt_d            = '0;
                    state_d          = GRANT_D;
                end
            end
            GRANT_I, GRANT_D: begin
                if (ext_data_ready) begin
                    imem_data_ready  = (state_q == GRANT_I);
                    dmem_data_ready  = (state_q == GRANT_D);
                    ext_addr_valid_d = 1'b0;
                    ext_wdv_d        = 1'b0;
                    last_dmem_d      = (state_q == GRANT_D);
                    state_d          = TURN;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    // completion above takes priority over a coincident timeout
                    if (cnt_q == TIMEOUT_LAST) begin
                        bus_error        = 1'b1;
                        ext_addr_valid_d = 1'b0;
                        ext_wdv_d        = 1'b0;
                        state_d          = TURN;
                    end
                end
            end
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= IDLE;
            ext_addr_valid_q <= 1'b0;
            ext_addr_q       <= '0;
            ext_wdv_q        <= 1'b0;
            ext_wdata_q      <= '0;
            cnt_q            <= '0;
            last_dmem_q      <= 1'b1;
        end else begin
            state_q          <= state_d;
            ext_addr_valid_q <= ext_addr_valid_d;
            ext_addr_q       <= ext_addr_d;
            ext_wdv_q        <= ext_wdv_d;
            ext_wdata_q      <= ext_wdata_d;
            cnt_q            <= cnt_d;
            last_dmem_q      <= last_dmem_d;
        end
    end

    assign ext_addr_valid       = ext_addr_valid_q;
    assign ext_addr             = ext_addr_q;
    assign ext_write_data_valid = ext_wdv_q;
    assign ext_write_data       = ext_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected completions,
// a negedge monitor checks them as the DUT signals ready/bus_error.
module tb_mem_arbiter;

    localparam int unsigned TO = 8;

    logic         clk;
    logic         rst;
    logic         imem_addr_valid;
    logic [31:0]  imem_addr;
    logic         imem_data_ready;
    logic         dmem_addr_valid;
    logic [31:0]  dmem_addr;
    logic         dmem_write_data_valid;
    logic [511:0] dmem_write_data;
    logic         dmem_data_ready;
    logic         ext_addr_valid;
    logic [31:0]  ext_addr;
    logic         ext_write_data_valid;
    logic [511:0] ext_write_data;
    logic         ext_data_ready;
    logic         bus_error;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .imem_addr_valid      (imem_addr_valid),
        .imem_addr            (imem_addr),
        .imem_data_ready      (imem_data_ready),
        .dmem_addr_valid      (dmem_addr_valid),
        .dmem_addr            (dmem_addr),
        .dmem_write_data_valid(dmem_write_data_valid),
        .dmem_write_data      (dmem_write_data),
        .dmem_data_ready      (dmem_data_ready),
        .ext_addr_valid       (ext_addr_valid),
        .ext_addr             (ext_addr),
        .ext_write_data_valid (ext_write_data_valid),
        .ext_write_data       (ext_write_data),
        .ext_data_ready       (ext_data_ready),
        .bus_error            (bus_error)
    );

    // kind: 0 = imem completion, 1 = dmem completion, 2 = bus_error abort
    typedef struct {
        int           kind;
        logic [31:0]  addr;
        logic         wdv;
        logic [511:0] wdata;
        int           waitc;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got no grant within bound, required grant", name);
    endtask

    // ---------------- monitor ----------------
    int cyc = 0;
    int g_cyc = 0;
    int turn_chk = 0;
    logic prev_av = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        int   kobs;
        cyc++;
        if (!rst) begin
            turn_chk = 0;
            prev_av  = 1'b0;
        end else begin
            if (turn_chk > 0) begin
                check("turn_gap_addr_valid", ext_addr_valid, 1'b0);
                turn_chk--;
            end
            if (ext_addr_valid && !prev_av) g_cyc = cyc;
            if (ext_addr_valid && sb.size() > 0) begin
                check("hold_addr", ext_addr, sb[0].addr);
                check("hold_wdv", ext_write_data_valid, sb[0].wdv);
                if (sb[0].wdv) check("hold_wdata", ext_write_data, sb[0].wdata);
            end
            if (int'(imem_data_ready) + int'(dmem_data_ready) + int'(bus_error) > 1) begin
                n_chk++;
                n_fail++;
                $display("FAIL multi_pulse: got i=%0b d=%0b err=%0b, required at most one",
                         imem_data_ready, dmem_data_ready, bus_error);
            end
            if (imem_data_ready || dmem_data_ready || bus_error) begin
                kobs = imem_data_ready ? 0 : (dmem_data_ready ? 1 : 2);
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_event: got kind %0d, required none", kobs);
                end else begin
                    e = sb.pop_front();
                    check("event_kind", kobs, e.kind);
                    check("event_wait_cycle", cyc - g_cyc + 1, e.waitc);
                    check("event_addr", ext_addr, e.addr);
                    turn_chk = 2;
                end
            end
            prev_av = ext_addr_valid;
        end
    end

    // ---------------- stimulus ----------------
    function automatic exp_t mk(input int kind, input logic [31:0] addr, input logic wdv,
                                input logic [511:0] wdata, input int waitc);
        exp_t e;
        e.kind = kind; e.addr = addr; e.wdv = wdv; e.wdata = wdata; e.waitc = waitc;
        return e;
    endfunction

    task automatic wait_grant();
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (ext_addr_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) bound_fail("grant_bound");
    endtask

    // Called in the first grant cycle; n = wait cycle carrying ready, 0 = never respond
    task automatic respond(input int n);
        if (n == 0) begin
            repeat (TO) begin @(posedge clk); #1; end
        end else begin
            repeat (n - 1) begin @(posedge clk); #1; end
            ext_data_ready = 1'b1;
            @(posedge clk); #1;
            ext_data_ready = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_txn(input bit is_d, input logic [31:0] addr, input logic wdv,
                          input logic [511:0] wdata, input int n);
        sb.push_back(mk(n == 0 ? 2 : int'(is_d), addr, is_d ? wdv : 1'b0, wdata, n == 0 ? int'(TO) : n));
        if (is_d) begin
            dmem_addr_valid = 1'b1; dmem_addr = addr;
            dmem_write_data_valid = wdv; dmem_write_data = wdata;
        end else begin
            imem_addr_valid = 1'b1; imem_addr = addr;
        end
        @(posedge clk); #1;
        check("latency_addr_valid", ext_addr_valid, 1'b1);
        check("latency_addr", ext_addr, addr);
        imem_addr_valid = 1'b0; dmem_addr_valid = 1'b0;
        imem_addr = ~addr; dmem_addr = ~addr;
        dmem_write_data = ~wdata; dmem_write_data_valid = ~wdv;
        respond(n);
    endtask

    logic [511:0] pat_a5, pat_b;

    initial begin
        pat_a5 = {64{8'hA5}};
        pat_b  = {16{32'h1357_9BDF}};
        rst = 1'b1;
        imem_addr_valid = 1'b0; imem_addr = '0;
        dmem_addr_valid = 1'b0; dmem_addr = '0;
        dmem_write_data_valid = 1'b0; dmem_write_data = '0;
        ext_data_ready = 1'b0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_addr_valid", ext_addr_valid, 1'b0);
        check("reset_addr", ext_addr, 32'h0);
        check("reset_wdv", ext_write_data_valid, 1'b0);
        check("reset_wdata", ext_write_data, 512'h0);
        check("reset_bus_error", bus_error, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;

        do_txn(1'b0, 32'h0000_0040, 1'b0, '0, 3);
        do_txn(1'b1, 32'h0000_8000, 1'b1, pat_a5, 4);
        do_txn(1'b1, 32'h1234_5680, 1'b0, pat_b, 1);

        // last served was dcache: continuous requests alternate I, D, I, D
        sb.push_back(mk(0, 32'h0000_0100, 1'b0, '0, 2));
        sb.push_back(mk(1, 32'h0000_0200, 1'b1, pat_b, 2));
        sb.push_back(mk(0, 32'h0000_0100, 1'b0, '0, 2));
        sb.push_back(mk(1, 32'h0000_0200, 1'b1, pat_b, 2));
        imem_addr_valid = 1'b1; imem_addr = 32'h0000_0100;
        dmem_addr_valid = 1'b1; dmem_addr = 32'h0000_0200;
        dmem_write_data_valid = 1'b1; dmem_write_data = pat_b;
        for (int t = 0; t < 4; t++) begin
            wait_grant();
            respond(2);
        end
        imem_addr_valid = 1'b0; dmem_addr_valid = 1'b0;

        do_txn(1'b0, 32'h0000_0300, 1'b0, '0, 0);
        ext_data_ready = 1'b1;
        @(posedge clk); #1;
        ext_data_ready = 1'b0;
        @(posedge clk); #1;
        do_txn(1'b1, 32'h0000_0400, 1'b1, pat_a5, int'(TO));

        // reset mid GRANT_D with a pending icache request
        dmem_addr_valid = 1'b1; dmem_addr = 32'h0000_0500;
        dmem_write_data_valid = 1'b1; dmem_write_data = pat_a5;
        @(posedge clk); #1;
        check("rst_test_grant", ext_addr_valid, 1'b1);
        imem_addr_valid = 1'b1; imem_addr = 32'h0000_0600;
        @(posedge clk); #1;
        ext_data_ready = 1'b1;
        rst = 1'b0;
        #1;
        check("midrst_addr_valid", ext_addr_valid, 1'b0);
        check("midrst_addr", ext_addr, 32'h0);
        check("midrst_wdv", ext_write_data_valid, 1'b0);
        check("midrst_wdata", ext_write_data, 512'h0);
        check("midrst_dmem_ready", dmem_data_ready, 1'b0);
        check("midrst_imem_ready", imem_data_ready, 1'b0);
        check("midrst_bus_error", bus_error, 1'b0);
        ext_data_ready = 1'b0;
        sb.push_back(mk(0, 32'h0000_0600, 1'b0, '0, 2));
        sb.push_back(mk(1, 32'h0000_0500, 1'b1, pat_a5, 2));
        @(posedge clk); #1;
        rst = 1'b1;
        for (int t = 0; t < 2; t++) begin
            wait_grant();
            respond(2);
        end
        imem_addr_valid = 1'b0; dmem_addr_valid = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
